// File: rtl/spi_rd_rx_if.sv
// ASIC-side handshake of the configuration-link receive path: burst
// request/command toward the FPGA pad, and the ready/req read port of the
// receive FIFO.
interface spi_rd_rx_if #(
  parameter int SPI_WIDTH = 32
);
  logic                 config_paulse;
  logic [3:0]           config_data;
  logic                 config_req;
  logic [3:0]           config_cmd;
  logic                 config_ready;
  logic                 rd_req;
  logic                 rd_ready;
  logic [SPI_WIDTH-1:0] rd_data;
  logic                 rd_done;
  logic                 overflow;

  // ASIC side: starts bursts and pops words.
  modport master (
    output config_paulse, config_data, rd_req,
    input  config_req, config_cmd, config_ready, rd_ready, rd_data, rd_done, overflow
  );

  // Receive block side.
  modport slave (
    input  config_paulse, config_data, rd_req,
    output config_req, config_cmd, config_ready, rd_ready, rd_data, rd_done, overflow
  );
endinterface

// File: rtl/spi_rd_rx.sv
// Receive path of the chip/FPGA configuration link. The FPGA clocks 32-bit
// words over the SPI pads; the pads are oversampled in clk_chip, words are
// buffered in a small show-ahead FIFO and handed to the ASIC via ready/req.
module spi_rd_rx #(
  parameter int SPI_WIDTH       = 32,
  parameter int ADDR_WIDTH_FIFO = 3,
  parameter int TX_WIDTH        = 20,
  parameter int BURST_LEN       = 64
) (
  input  logic                 clk_chip,
  input  logic                 reset_chip,
  input  logic                 O_spi_sck,
  input  logic                 O_spi_cs_n,
  input  logic [SPI_WIDTH-1:0] I_spi_data,
  output logic                 rd_hold,
  spi_rd_rx_if.slave           bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH_FIFO;

  typedef logic [ADDR_WIDTH_FIFO:0] cnt_t;
  typedef logic [TX_WIDTH-1:0]      rx_t;

  // Backpressure threshold leaves room for the words already in flight
  // through the pad synchronizers plus the FPGA's reaction time.
  localparam cnt_t FULL_LEVEL = cnt_t'(DEPTH);
  localparam cnt_t HOLD_LEVEL = cnt_t'(DEPTH - 3);
  localparam rx_t  BURST_TOP  = rx_t'(BURST_LEN);
  localparam rx_t  BURST_LAST = rx_t'(BURST_LEN - 1);

  typedef enum logic [2:0] {IDLE, CONFIG, WAIT, RD_DATA, DRAIN} state_t;

  state_t               state;
  logic                 config_req;
  logic [3:0]           config_cmd;
  rx_t                  rx_count;

  logic                 sck_1, sck_2, sck_3;
  logic                 cs_1, cs_2;
  logic [SPI_WIDTH-1:0] data_1, data_2;

  logic [SPI_WIDTH-1:0]       mem [DEPTH];
  logic [ADDR_WIDTH_FIFO-1:0] wr_ptr, rd_ptr;
  cnt_t                       count;
  logic                       overflow;

  logic sck_rise, push, pop, push_ok, fifo_empty, fifo_full;

  // Two-flop synchronizers for the asynchronous pads plus one edge register
  // on sck; data rides the same depth so it lines up with sck_2.
  always_ff @(posedge clk_chip) begin
    // NOTE: every clocked block uses non-blocking assignments so all flops
    // sample their inputs from the same pre-edge values.
    if (reset_chip) begin
      sck_1  <= 1'b0;
      sck_2  <= 1'b0;
      sck_3  <= 1'b0;
      cs_1   <= 1'b1;
      cs_2   <= 1'b1;
      data_1 <= '0;
      data_2 <= '0;
    end else begin
      sck_1  <= O_spi_sck;
      sck_2  <= sck_1;
      sck_3  <= sck_2;
      cs_1   <= O_spi_cs_n;
      cs_2   <= cs_1;
      data_1 <= I_spi_data;
      data_2 <= data_1;
    end
  end

  assign sck_rise   = sck_2 & ~sck_3;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_LEVEL);
  assign push       = (state == RD_DATA) && sck_rise && !cs_2 && (rx_count < BURST_TOP);
  assign pop        = bus.rd_req && !fifo_empty;
  assign push_ok    = push && (!fifo_full || pop);

  // Burst sequencer: request, wait for chip select, collect, then drain.
  always_ff @(posedge clk_chip) begin
    if (reset_chip) begin
      state      <= IDLE;
      config_req <= 1'b0;
      config_cmd <= '0;
      rx_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.config_paulse) begin
            config_cmd <= bus.config_data;
            state      <= CONFIG;
          end
        end
        CONFIG: begin
          config_req <= 1'b1;
          state      <= WAIT;
        end
        WAIT: begin
          if (!cs_2) begin
            config_req <= 1'b0;
            state      <= RD_DATA;
          end
        end
        RD_DATA: begin
          // Edges are counted even when the word is dropped on overflow.
          if (push) rx_count <= rx_count + 1'b1;
          if (cs_2 || (push && rx_count == BURST_LAST)) state <= DRAIN;
        end
        DRAIN: begin
          if (fifo_empty) begin
            rx_count <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk_chip) begin
    if (reset_chip) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk_chip) begin
    // NOTE: the storage array has no reset; emptiness is carried by count,
    // and rd_data is forced to zero while the FIFO is empty.
    if (push_ok) mem[wr_ptr] <= data_2;
  end

  assign rd_hold          = (count >= HOLD_LEVEL);
  assign bus.config_req   = config_req;
  assign bus.config_cmd   = config_cmd;
  assign bus.config_ready = (state == IDLE);
  assign bus.rd_ready     = !fifo_empty;
  assign bus.rd_data      = fifo_empty ? '0 : mem[rd_ptr];
  assign bus.rd_done      = (state == DRAIN) && fifo_empty;
  assign bus.overflow     = overflow;

endmodule

// File: doc/spi_rd_rx.md
# spi_rd_rx

ASIC-side receive path of the chip/FPGA configuration link. The ASIC requests a burst; the FPGA then clocks 32-bit words into the chip over the SPI pads (O_spi_sck, O_spi_cs_n, I_spi_data). The block oversamples those pads in the clk_chip domain, buffers words in a small synchronous FIFO, and hands them to the ASIC through a ready/req handshake. It mirrors the chip-to-FPGA write path, so both link directions share one pad protocol.

## Interface
Parameters:
- SPI_WIDTH, 32, SPI data word width.
- ADDR_WIDTH_FIFO, 3, FIFO address bits (depth 2^ADDR_WIDTH_FIFO = 8).
- TX_WIDTH, 20, width of rx_count.
- BURST_LEN, 64, words accepted per burst.

Ports:
- clk_chip  in  1  ASIC clock; the only clock.
- reset_chip  in  1  synchronous, active-high reset.
- O_spi_sck  in  1  FPGA SPI clock pad; asynchronous to clk_chip.
- O_spi_cs_n  in  1  FPGA chip select pad, active low.
- I_spi_data  in  SPI_WIDTH  FPGA data pad; FPGA changes it on falling O_spi_sck.
- config_req  out  1  burst request to the FPGA pad.
- config_cmd  out  4  command latched from config_data; stable while config_req=1.
- rd_hold  out  1  backpressure to the FPGA: stop issuing O_spi_sck edges.
- config_ready  out  1  high in IDLE only.
- config_paulse  in  1  one-cycle burst start from the ASIC.
- config_data  in  4  burst command from the ASIC.
- rd_ready  out  1  FIFO not empty.
- rd_req  in  1  ASIC pop.
- rd_data  out  SPI_WIDTH  FIFO head (show-ahead); 0 when empty.
- rd_done  out  1  one-cycle pulse at burst end.
- overflow  out  1  sticky error: a word was dropped.

## Operation
- Pad sync: O_spi_sck and O_spi_cs_n each pass through 2 flops (sck_2, cs_2), then 1 edge register (sck_3). A rising edge is sck_2 & ~sck_3. I_spi_data passes through 2 flops aligned with sck_2.
- FSM states: IDLE, CONFIG, WAIT, RD_DATA, DRAIN.
  - IDLE: config_paulse latches config_cmd<=config_data and moves to CONFIG.
  - CONFIG: sets config_req<=1. Moves to WAIT.
  - WAIT: cs_2==0 moves to RD_DATA and clears config_req.
  - RD_DATA: each sck rising edge with cs_2==0 pushes the synchronized data and increments rx_count. Moves to DRAIN when the push count reaches BURST_LEN or cs_2 returns to 1. Edges after BURST_LEN are ignored.
  - DRAIN: when the FIFO is empty, pulse rd_done, clear rx_count, and return to IDLE.
- config_paulse outside IDLE is ignored.
- FIFO:
  - Pop when rd_req && rd_ready. rd_req with an empty FIFO is ignored.
  - A push while full with no pop in the same cycle drops the word and sets overflow. overflow clears only on reset.
  - A push and pop in the same cycle while full is accepted.
- rd_hold = (FIFO count >= depth-3). This covers the FPGA reaction time plus the sync latency.
- rx_count is a TX_WIDTH-bit counter and saturates at BURST_LEN.

## Timing
- Reset values (one clk_chip edge with reset_chip=1):
  - State IDLE, so config_ready=1.
  - config_req=0, config_cmd=0, rd_hold=0, rd_ready=0, rd_data=0, rd_done=0, overflow=0.
  - FIFO and all sync flops cleared to the idle pad levels: sck=0, cs_n=1.
- Reset mid-burst aborts the burst immediately and discards FIFO contents.
- config_paulse to config_req=1: 2 cycles (IDLE→CONFIG, CONFIG sets the register).
- Pad to push latency: 3 clk_chip cycles after the O_spi_sck rise. From a push to rd_ready=1: 1 cycle.
- Link constraints:
  - O_spi_sck high and low phases each >= 3 clk_chip cycles.
  - I_spi_data stable from 3 cycles before to 3 cycles after each sck rise.
  - After rd_hold rises, the FPGA may issue at most 2 further edges.
- rd_done asserts exactly 1 cycle, in the cycle DRAIN sees an empty FIFO; config_ready=1 on the next cycle.

## Test plan
- Reset, then idle pads for 20 cycles: config_ready=1, rd_ready=0, all other outputs 0.
- config_paulse with config_data=4'hA: config_cmd=4'hA and config_req=1 2 cycles later. Then cs_n low and 64 words 0x0000_0000..0x0000_003F at sck period 8 cycles, with rd_req tied to 1: the ASIC reads 64 words in order, rd_done pulses once, config_req falls on entering RD_DATA.
- 70 sck edges in one burst: only 64 words delivered; rx_count stays at 64.
- rd_req held 0 during the burst: rd_hold rises at count 5. An FPGA model honouring rd_hold gives no overflow. A model ignoring rd_hold gives overflow=1 and the 9th word is dropped.
- cs_n raised after 10 words: the state goes to DRAIN, 10 words are read out, rd_done pulses, then IDLE.
- reset_chip asserted mid-burst after 20 words: next cycle all outputs at reset values, FIFO empty, and a new config_paulse starts a clean burst.
